addsub_share_arbiter: RTL

//  Shares one external 32-bit adder_subtractor datapath (A, B, cin -> sum, cout)

---
 rtl/addsub_share_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/addsub_share_arbiter.sv
// addsub_share_arbiter: time-shares one external adder/subtractor datapath
// between NREQ requesters. A grant latches the winner's operands (B already
// inverted and carry forced for subtraction), the datapath result is
// captured one cycle later and held as a tagged response until accepted.
//
// Build option: define ADDSUB_ARB_RR_EN for round-robin arbitration with a
// rotating pointer; otherwise the lowest-index valid requester always wins.

module addsub_share_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDW   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_sub,
  input  logic [NREQ-1:0]         req_cin,
  output logic [WIDTH-1:0]        dp_a,
  output logic [WIDTH-1:0]        dp_b,
  output logic                    dp_cin,
  input  logic [WIDTH-1:0]        dp_sum,
  input  logic                    dp_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [IDW-1:0]          rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout
);

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  state_e           state_q;

  // Operand registers double as the datapath drive
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             cin_q;
  logic [IDW-1:0]   id_q;

  logic [WIDTH-1:0] rsp_sum_q;
  logic             rsp_cout_q;
  logic [IDW-1:0]   rsp_id_q;
  logic             rsp_valid_q;

  logic             any_valid;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

  assign any_valid = |req_valid;

`ifdef ADDSUB_ARB_RR_EN
  logic [IDW-1:0]  ptr_q;
  logic [NREQ-1:0] rot;
  logic [IDW-1:0]  off;
  logic [IDW:0]    sum_id;

  // Round-robin pick: rotate valids so ptr lands at bit 0, find the lowest
  // set bit, then rotate the offset back into requester numbering.
  always_comb begin
    rot = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      int idx;
      idx = int'(ptr_q) + k;
      if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
      rot[k] = req_valid[idx];
    end
    off = '0;
    for (int j = int'(NREQ) - 1; j >= 0; j--) begin
      if (rot[j]) off = IDW'(j);
    end
    sum_id = {1'b0, ptr_q} + {1'b0, off};
    if (sum_id >= (IDW+1)'(NREQ)) sum_id = sum_id - (IDW+1)'(NREQ);
    grant_id = sum_id[IDW-1:0];
  end
`else
  // Fixed priority: lowest-index valid requester wins
  always_comb begin
    grant_id = '0;
    for (int j = int'(NREQ) - 1; j >= 0; j--) begin
      if (req_valid[j]) grant_id = IDW'(j);
    end
  end
`endif

  // One-hot grant pulse, only while idle
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && any_valid) req_ready[grant_id] = 1'b1;
  end

  // Select the winner's operands and fold subtraction into B/cin
  always_comb begin
    sel_a   = req_a[grant_id*WIDTH +: WIDTH];
    sel_b   = req_b[grant_id*WIDTH +: WIDTH];
    b_eff   = req_sub[grant_id] ? ~sel_b : sel_b;
    cin_eff = req_sub[grant_id] | req_cin[grant_id];
  end

  // Controller FSM with operand latching and result capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      cin_q       <= 1'b0;
      id_q        <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
`ifdef ADDSUB_ARB_RR_EN
      ptr_q       <= '0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (any_valid) begin
            a_q     <= sel_a;
            b_q     <= b_eff;
            cin_q   <= cin_eff;
            id_q    <= grant_id;
            state_q <= StExec;
`ifdef ADDSUB_ARB_RR_EN
            ptr_q   <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
`endif
          end
        end
        StExec: begin
          rsp_sum_q   <= dp_sum;
          rsp_cout_q  <= dp_cout;
          rsp_id_q    <= id_q;
          rsp_valid_q <= 1'b1;
          state_q     <= StResp;
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign dp_a      = a_q;
  assign dp_b      = b_q;
  assign dp_cin    = cin_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_cout  = rsp_cout_q;

endmodule
